// File: rtl/password_lock_fsm.sv
// password_lock_fsm: sequential multi-digit password lock.
// Digits are collected one per digit_valid strobe and compared against PASSWORD.
// A correct code opens the gate for GATE_CYCLES cycles. A wrong code pulses wpo
// and uses up one try. Running out of tries starts a LOCK_CYCLES lockout.
// All outputs are registered.
// Optional feature macro: DIGIT_TIMEOUT_EN. When it is defined, an entry that
// stalls for TIMEOUT_CYCLES cycles in COLLECT is treated as a failed attempt.
// Handshake: digit_in is sampled on a rising clk edge only when digit_valid=1.
// There is no back-pressure. Digits that arrive outside COLLECT are dropped.
module password_lock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASSWORD = 16'hA5C3,
  parameter int MAX_TRIES      = 3,
  parameter int GATE_CYCLES    = 8,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enter,
  input  logic                           exit,
  input  logic [DIGIT_W-1:0]             digit_in,
  input  logic                           digit_valid,
  output logic                           gate,
  output logic                           wpo,
  output logic                           locked,
  output logic                           busy,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int TW     = $clog2(MAX_TRIES + 1);
  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GW     = $clog2(GATE_CYCLES + 1);
  localparam int LW     = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            mis_q, mis_d;
  logic            gate_q, gate_d;
  logic            wpo_q, wpo_d;
  logic            locked_q, locked_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [GW-1:0]   gtmr_q, gtmr_d;
  logic [LW-1:0]   ltmr_q, ltmr_d;
  logic [CODE_W-1:0]  pw_shift;
  logic [DIGIT_W-1:0] pw_digit;

`ifdef DIGIT_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] tcnt_q, tcnt_d;
`endif

  // Select the expected digit for the current index. Digit 0 is the MS slice.
  always_comb begin
    pw_shift = PASSWORD << (int'(idx_q) * DIGIT_W);
    pw_digit = pw_shift[CODE_W-1 -: DIGIT_W];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    gate_d   = gate_q;
    wpo_d    = 1'b0;
    locked_d = locked_q;
    busy_d   = busy_q;
    tries_d  = tries_q;
    gtmr_d   = gtmr_q;
    ltmr_d   = ltmr_q;
`ifdef DIGIT_TIMEOUT_EN
    tcnt_d   = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        // When enter and exit arrive together, exit wins and the lock stays idle.
        if (enter && !exit) begin
          state_d = COLLECT;
          idx_d   = '0;
          mis_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef DIGIT_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      COLLECT: begin
        if (exit) begin
          // An abort costs no try and produces no wpo pulse.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (digit_valid) begin
          mis_d = mis_q | (digit_in != pw_digit);
`ifdef DIGIT_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (idx_q == IW'(NUM_DIGITS - 1)) state_d = CHECK;
          else                              idx_d   = idx_q + IW'(1);
        end
`ifdef DIGIT_TIMEOUT_EN
        else if (tcnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
          // A stalled entry goes through CHECK as a forced miscompare.
          mis_d   = 1'b1;
          state_d = CHECK;
        end else begin
          tcnt_d = tcnt_q + TOW'(1);
        end
`endif
      end
      CHECK: begin
        busy_d = 1'b0;
        if (!mis_q) begin
          state_d = OPEN;
          gate_d  = 1'b1;
          tries_d = TW'(MAX_TRIES);
          gtmr_d  = GW'(GATE_CYCLES - 1);
        end else begin
          wpo_d = 1'b1;
          if (tries_q <= TW'(1)) begin
            tries_d  = '0;
            state_d  = LOCKOUT;
            locked_d = 1'b1;
            ltmr_d   = LW'(LOCK_CYCLES - 1);
          end else begin
            tries_d = tries_q - TW'(1);
            state_d = IDLE;
          end
        end
      end
      OPEN: begin
        if (exit || gtmr_q == '0) begin
          state_d = IDLE;
          gate_d  = 1'b0;
        end else begin
          gtmr_d = gtmr_q - GW'(1);
        end
      end
      LOCKOUT: begin
        if (ltmr_q == '0) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          tries_d  = TW'(MAX_TRIES);
        end else begin
          ltmr_d = ltmr_q - LW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        gate_d   = 1'b0;
        locked_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      gate_q   <= 1'b0;
      wpo_q    <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      tries_q  <= TW'(MAX_TRIES);
      gtmr_q   <= '0;
      ltmr_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      gate_q   <= gate_d;
      wpo_q    <= wpo_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      tries_q  <= tries_d;
      gtmr_q   <= gtmr_d;
      ltmr_q   <= ltmr_d;
    end
  end

`ifdef DIGIT_TIMEOUT_EN
  // Counts the cycles spent waiting for a digit in COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end
`endif

  assign gate       = gate_q;
  assign wpo        = wpo_q;
  assign locked     = locked_q;
  assign busy       = busy_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_password_lock_fsm.sv
// Testbench for password_lock_fsm with the default parameters (code A5C3,
// 3 tries, 8-cycle gate, 16-cycle lockout).
// Each expected output word is {gate, wpo, locked, busy, tries_left[1:0]}.
module tb_password_lock_fsm;

  logic       clk;
  logic       rst_n;
  logic       enter;
  logic       exit;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       gate;
  logic       wpo;
  logic       locked;
  logic       busy;
  logic [1:0] tries_left;

  typedef struct {
    string      nm;
    logic       en;
    logic       ex;
    logic       dv;
    logic [3:0] d;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [15:0] code  = 16'hA5C3;

  password_lock_fsm dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .exit(exit),
    .digit_in(digit_in), .digit_valid(digit_valid),
    .gate(gate), .wpo(wpo), .locked(locked), .busy(busy),
    .tries_left(tries_left)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] e(input logic g, input logic w, input logic l,
                                   input logic b, input logic [1:0] t);
    return {g, w, l, b, t};
  endfunction

  // Scoreboard: pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_pop();
    logic [5:0] exp;
    logic [5:0] act;
    string      nm;
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    act = {gate, wpo, locked, busy, tries_left};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got g/w/l/b/t=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm,
               act[5], act[4], act[3], act[2], act[1:0],
               exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Driver: apply inputs for one cycle, then check the outputs after the edge.
  task automatic step(input string nm, input logic en, input logic ex, input logic dv,
                      input logic [3:0] d, input logic [5:0] exp);
    @(negedge clk);
    enter = en; exit = ex; digit_valid = dv; digit_in = d;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic add(input string nm, input logic en, input logic ex, input logic dv,
                     input logic [3:0] d, input logic [5:0] exp);
    vec_t v;
    v.nm = nm; v.en = en; v.ex = ex; v.dv = dv; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Enter one full code by hand. tries_in is the tries_left value during entry.
  task automatic enter_code(input string nm, input logic [15:0] c, input logic [1:0] tries_in);
    step(nm, 1'b1, 1'b0, 1'b0, 4'h0, e(0, 0, 0, 1, tries_in));
    for (int i = 0; i < 4; i++)
      step(nm, 1'b0, 1'b0, 1'b1, c[15-4*i -: 4], e(0, 0, 0, 1, tries_in));
  endtask

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic async_reset(input string nm);
    @(negedge clk);
    enter = 1'b0; exit = 1'b0; digit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(e(0, 0, 0, 0, 2'd3));
    name_q.push_back(nm);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enter = 1'b0; exit = 1'b0; digit_valid = 1'b0; digit_in = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(e(0, 0, 0, 0, 2'd3));
    name_q.push_back("reset_values");
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code: the gate opens two edges after the last digit and stays open 8 cycles.
    add("t1_enter", 1, 0, 0, 0, e(0, 0, 0, 1, 3));
    for (int i = 0; i < 4; i++) add("t1_digit", 0, 0, 1, code[15-4*i -: 4], e(0, 0, 0, 1, 3));
    add("t1_open", 0, 0, 0, 0, e(1, 0, 0, 0, 3));
    add("t1_hold_enter_ignored", 1, 0, 0, 0, e(1, 0, 0, 0, 3));
    add("t1_hold_digit_ignored", 0, 0, 1, 4'hA, e(1, 0, 0, 0, 3));
    for (int i = 0; i < 5; i++) add("t1_hold", 0, 0, 0, 0, e(1, 0, 0, 0, 3));
    add("t1_close", 0, 0, 0, 0, e(0, 0, 0, 0, 3));
    // Wrong last digit: a single wpo pulse and one try used.
    add("t2_enter", 1, 0, 0, 0, e(0, 0, 0, 1, 3));
    add("t2_d0", 0, 0, 1, 4'hA, e(0, 0, 0, 1, 3));
    add("t2_d1", 0, 0, 1, 4'h5, e(0, 0, 0, 1, 3));
    add("t2_d2", 0, 0, 1, 4'hC, e(0, 0, 0, 1, 3));
    add("t2_d3", 0, 0, 1, 4'h4, e(0, 0, 0, 1, 3));
    add("t2_wpo", 0, 0, 0, 0, e(0, 1, 0, 0, 2));
    add("t2_wpo_end", 0, 0, 0, 0, e(0, 0, 0, 0, 2));
    // Abort with a same-cycle digit, then the correct code reloads the tries.
    add("t4_enter", 1, 0, 0, 0, e(0, 0, 0, 1, 2));
    add("t4_d0", 0, 0, 1, 4'hA, e(0, 0, 0, 1, 2));
    add("t4_d1", 0, 0, 1, 4'h5, e(0, 0, 0, 1, 2));
    add("t4_abort", 0, 1, 1, 4'hC, e(0, 0, 0, 0, 2));
    add("t4_after_abort", 0, 0, 0, 0, e(0, 0, 0, 0, 2));
    add("t4_idle_digit", 0, 0, 1, 4'hA, e(0, 0, 0, 0, 2));
    add("t4_enter2", 1, 0, 0, 0, e(0, 0, 0, 1, 2));
    for (int i = 0; i < 4; i++) add("t4_digit", 0, 0, 1, code[15-4*i -: 4], e(0, 0, 0, 1, 2));
    add("t4_open", 0, 0, 0, 0, e(1, 0, 0, 0, 3));
    // Exit during the 3rd open cycle closes the gate on the next edge.
    add("t5_open2", 0, 0, 0, 0, e(1, 0, 0, 0, 3));
    add("t5_exit", 0, 1, 0, 0, e(0, 0, 0, 0, 3));
    add("t5_enter_exit", 1, 1, 0, 0, e(0, 0, 0, 0, 3));
    add("t5_still_idle", 0, 0, 1, 4'hA, e(0, 0, 0, 0, 3));
    // Three wrong codes in a row lead to a 16-cycle lockout.
    for (int k = 0; k < 3; k++) begin
      add("t3_enter", 1, 0, 0, 0, e(0, 0, 0, 1, 2'(3 - k)));
      for (int i = 0; i < 4; i++) add("t3_bad", 0, 0, 1, 4'h0, e(0, 0, 0, 1, 2'(3 - k)));
      add("t3_wpo", 0, 0, 0, 0, e(0, 1, k == 2, 0, 2'(2 - k)));
      if (k < 2) add("t3_gap", 0, 0, 0, 0, e(0, 0, 0, 0, 2'(2 - k)));
    end
    for (int i = 0; i < 15; i++)
      add("t3_locked", (i % 5) == 0, i == 7, (i % 5) != 0, code[15-4*(i%4) -: 4],
          e(0, 0, 1, 0, 0));
    add("t3_unlock", 0, 0, 0, 0, e(0, 0, 0, 0, 3));
    add("t3_enter_after", 1, 0, 0, 0, e(0, 0, 0, 1, 3));
    add("t3_exit_after", 0, 1, 0, 0, e(0, 0, 0, 0, 3));

    foreach (vecs[i]) step(vecs[i].nm, vecs[i].en, vecs[i].ex, vecs[i].dv, vecs[i].d, vecs[i].exp);

    // Reset during COLLECT, then check that the digit index restarts from 0.
    step("r1_enter", 1'b1, 1'b0, 1'b0, 4'h0, e(0, 0, 0, 1, 3));
    step("r1_d0", 1'b0, 1'b0, 1'b1, 4'hA, e(0, 0, 0, 1, 3));
    async_reset("r1_reset_mid_collect");
    enter_code("r1_code", code, 2'd3);
    step("r1_open", 1'b0, 1'b0, 1'b0, 4'h0, e(1, 0, 0, 0, 3));

    // Reset during LOCKOUT.
    async_reset("r2_reset_mid_open");
    enter_code("r2_bad1", 16'h0000, 2'd3);
    step("r2_wpo1", 1'b0, 1'b0, 1'b0, 4'h0, e(0, 1, 0, 0, 2));
    enter_code("r2_bad2", 16'h0000, 2'd2);
    step("r2_wpo2", 1'b0, 1'b0, 1'b0, 4'h0, e(0, 1, 0, 0, 1));
    enter_code("r2_bad3", 16'h0000, 2'd1);
    step("r2_lock", 1'b0, 1'b0, 1'b0, 4'h0, e(0, 1, 1, 0, 0));
    step("r2_locked", 1'b0, 1'b0, 1'b0, 4'h0, e(0, 0, 1, 0, 0));
    async_reset("r2_reset_mid_lockout");
    step("r2_after", 1'b1, 1'b0, 1'b0, 4'h0, e(0, 0, 0, 1, 3));
    step("r2_exit", 1'b0, 1'b1, 1'b0, 4'h0, e(0, 0, 0, 0, 3));

`ifdef DIGIT_TIMEOUT_EN
    // A stalled entry times out as a failed attempt.
    begin
      logic seen;
      seen = 1'b0;
      step("to_enter", 1'b1, 1'b0, 1'b0, 4'h0, e(0, 0, 0, 1, 3));
      step("to_d0", 1'b0, 1'b0, 1'b1, 4'hA, e(0, 0, 0, 1, 3));
      @(negedge clk);
      digit_valid = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk);
        #1;
        if (wpo) seen = 1'b1;
      end
      exp_q.push_back(e(0, 1, 0, 0, 2));
      name_q.push_back(seen ? "to_wpo" : "to_wpo_timeout_expired");
      check_pop();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
